// File: rtl/lfsr_to_code_phase.sv
// Recovers the GPS C/A code phase (0..1022) that produces a given G1/G2 snapshot.
// Optional TWO_STEP_EN: evaluate two chip candidates per search cycle.
module lfsr_to_code_phase (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [9:0] g1,
  input  logic [9:0] g2,
  output logic       busy,
  output logic       done,
  output logic [9:0] phase,
  output logic [1:0] err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEARCH,
    S_DONE
  } state_t;

  localparam logic [9:0] EPOCH     = 10'h3FF;
  localparam logic [9:0] LAST_CHIP = 10'd1022;

  function automatic logic [9:0] step_g1(input logic [9:0] g);
    return {g[8:0], g[2] ^ g[9]};
  endfunction

  function automatic logic [9:0] step_g2(input logic [9:0] g);
    return {g[8:0], g[1] ^ g[2] ^ g[5] ^ g[7] ^ g[8] ^ g[9]};
  endfunction

  state_t     state;
  logic [9:0] snap1, snap2;
  logic [9:0] rep1, rep2;
  logic [9:0] count;

  logic       match0;
  logic       g2_ok0;
`ifdef TWO_STEP_EN
  logic [9:0] rep1_b, rep2_b;
  logic       match1;
  logic       g2_ok1;
`endif

  always_comb begin
    match0 = (rep1 == snap1);
    g2_ok0 = (rep2 == snap2);
`ifdef TWO_STEP_EN
    rep1_b = step_g1(rep1);
    rep2_b = step_g2(rep2);
    // Candidate count+1 does not exist once count reaches the last chip.
    match1 = (count != LAST_CHIP) && (rep1_b == snap1);
    g2_ok1 = (rep2_b == snap2);
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      phase <= '0;
      err   <= 2'b00;
      count <= '0;
      snap1 <= '0;
      snap2 <= '0;
      rep1  <= EPOCH;
      rep2  <= EPOCH;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            snap1 <= g1;
            snap2 <= g2;
            rep1  <= EPOCH;
            rep2  <= EPOCH;
            count <= '0;
            busy  <= 1'b1;
            state <= S_SEARCH;
          end
        end

        S_SEARCH: begin
          // An all-zero G1 is a lock-up state the replica never reaches.
          if (snap1 == '0) begin
            phase <= '0;
            err   <= 2'b01;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end else if (match0) begin
            phase <= count;
            err   <= g2_ok0 ? 2'b00 : 2'b10;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
`ifdef TWO_STEP_EN
          end else if (match1) begin
            phase <= count + 10'd1;
            err   <= g2_ok1 ? 2'b00 : 2'b10;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            rep1  <= step_g1(rep1_b);
            rep2  <= step_g2(rep2_b);
            count <= count + 10'd2;
          end
`else
          end else begin
            rep1  <= step_g1(rep1);
            rep2  <= step_g2(rep2);
            count <= count + 10'd1;
          end
`endif
        end

        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_to_code_phase.sv
// Bench for lfsr_to_code_phase: directed vector table, boundary sweeps, randomized
// snapshots checked against a table-lookup reference, plus start-glitch and reset-abort sequences.
module tb_lfsr_to_code_phase;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [9:0] g1 = '0;
  logic [9:0] g2 = '0;
  logic       busy, done;
  logic [9:0] phase;
  logic [1:0] err;

  int checks = 0;
  int errors = 0;

  logic [9:0] g1tab [1023];
  logic [9:0] g2tab [1023];

  lfsr_to_code_phase dut (
    .clk(clk), .rst(rst), .start(start), .g1(g1), .g2(g2),
    .busy(busy), .done(done), .phase(phase), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      nm;
    logic [9:0] g1;
    logic [9:0] g2;
    int         ph;
    int         er;
  } vec_t;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  // Reference: the forward sequence is tabulated once, the inverse is a plain lookup.
  task automatic build_tables();
    logic [9:0] a, b;
    a = 10'h3FF;
    b = 10'h3FF;
    for (int i = 0; i < 1023; i++) begin
      g1tab[i] = a;
      g2tab[i] = b;
      a = {a[8:0], a[2] ^ a[9]};
      b = {b[8:0], b[1] ^ b[2] ^ b[5] ^ b[7] ^ b[8] ^ b[9]};
    end
  endtask

  task automatic ref_model(input logic [9:0] a, input logic [9:0] b, output int p, output int e);
    p = 0;
    e = 1;
    if (a != '0) begin
      for (int i = 0; i < 1023; i++) begin
        if (g1tab[i] == a) begin
          p = i;
          e = (g2tab[i] == b) ? 0 : 2;
          break;
        end
      end
    end
  endtask

  function automatic int exp_latency(input int p, input int e);
    if (e == 1) return 1;
`ifdef TWO_STEP_EN
    return p / 2 + 1;
`else
    return p + 1;
`endif
  endfunction

  task automatic run(input string nm, input logic [9:0] a, input logic [9:0] b,
                     input int ph, input int er, input int glitch_at);
    int  n;
    bit  seen;
    @(negedge clk);
    g1 = a;
    g2 = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    g1 = 10'($urandom);
    g2 = 10'($urandom);
    chk({nm, " busy"}, int'(busy), 1);
    n = 0;
    seen = 0;
    while (n < 1100 && !seen) begin
      if (n == glitch_at) begin
        start = 1'b1;
        g1 = 10'($urandom);
        g2 = 10'($urandom);
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      n++;
      if (done) seen = 1;
    end
    chk({nm, " latency"}, n, exp_latency(ph, er));
    chk({nm, " phase"}, int'(phase), ph);
    chk({nm, " err"}, int'(err), er);
    chk({nm, " busy_at_done"}, int'(busy), 0);
    @(posedge clk);
    #1;
    chk({nm, " done_pulse_width"}, int'(done), 0);
  endtask

  initial begin
    vec_t vt [7];
    int   p, e, pulses;
    logic [9:0] a, b;

    build_tables();
    vt[0] = '{"epoch",      10'h3FF, 10'h3FF, 0,    0};
    vt[1] = '{"step_one",   10'h3FE, 10'h3FE, 1,    0};
    vt[2] = '{"last_chip",  10'h1FF, 10'h1FF, 1022, 0};
    vt[3] = '{"g1_zero",    10'h000, 10'h155, 0,    1};
    vt[4] = '{"g2_bad",     10'h3FF, 10'h3FE, 0,    2};
    vt[5] = '{"g2_bad_p7",  g1tab[7], g2tab[8], 7,  2};
    vt[6] = '{"mid_p333",   g1tab[333], g2tab[333], 333, 0};

    // Reset held with start asserted: nothing may begin.
    start = 1'b1;
    g1 = 10'h3FF;
    g2 = 10'h3FF;
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset phase", int'(phase), 0);
    chk("reset err", int'(err), 0);
    @(negedge clk);
    rst = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("post_reset idle busy", int'(busy), 0);
    chk("post_reset idle done", int'(done), 0);

    foreach (vt[i]) run(vt[i].nm, vt[i].g1, vt[i].g2, vt[i].ph, vt[i].er, -1);

    for (int i = 0; i < 32; i++) run("sweep_lo", g1tab[i], g2tab[i], i, 0, -1);
    for (int i = 1000; i < 1023; i++) run("sweep_hi", g1tab[i], g2tab[i], i, 0, -1);

    for (int k = 0; k < 30; k++) begin
      a = 10'($urandom);
      if ($urandom_range(3) != 0) begin
        p = int'($urandom_range(1022));
        a = g1tab[p];
        b = ($urandom_range(3) != 0) ? g2tab[p] : 10'($urandom);
      end else begin
        b = 10'($urandom);
      end
      ref_model(a, b, p, e);
      run("random", a, b, p, e, -1);
    end

    run("glitch_start", g1tab[500], g2tab[500], 500, 0, 100);

    // Abort mid-search: outputs return to reset values and no done follows.
    @(negedge clk);
    g1 = g1tab[600];
    g2 = g2tab[600];
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (50) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("abort busy", int'(busy), 0);
    chk("abort done", int'(done), 0);
    chk("abort phase", int'(phase), 0);
    chk("abort err", int'(err), 0);
    @(negedge clk);
    rst = 1'b1;
    pulses = 0;
    for (int i = 0; i < 1100; i++) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
    end
    chk("abort no_done", pulses, 0);

    run("after_abort", g1tab[3], g2tab[3], 3, 0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lfsr_to_code_phase.md
Name: lfsr_to_code_phase

Overview:
Inverse of the code-phase-to-LFSR mapper. Takes a GPS C/A G1/G2 register snapshot and recovers the code phase 0..1022 that produces it. It does this by stepping local G1/G2 replicas from the all-ones epoch state and comparing them against the snapshot. Used by the acquisition/tracking side to convert a captured generator state back into a chip offset, and to cross-check the forward mapper.

Parameters:
None. The polynomials and the 1023-chip period are fixed by the C/A code definition.

Ports:
clk     input   1   system clock, rising edge
rst     input   1   synchronous, active-low reset
start   input   1   request pulse; sampled only in IDLE
g1      input   10  G1 state to resolve; bit k-1 = stage k
g2      input   10  G2 state to resolve; bit k-1 = stage k
busy    output  1   high while a search is in progress
done    output  1   one-cycle pulse: phase valid
phase   output  10  recovered code phase, held until next start
err     output  2   00 none, 01 all-zero G1, 10 G2 inconsistent with G1; valid with done

Behaviour:
- Reset (rst=0 at a rising edge): state IDLE, busy=0, done=0, phase=0, err=00, internal count=0, internal LFSRs=10'h3FF.
- LFSR definition, shared with the forward mapper:
  - phase 0 = all ones.
  - One chip step: next = {g[8:0], fb}.
  - G1: fb = g[2]^g[9].
  - G2: fb = g[1]^g[2]^g[5]^g[7]^g[8]^g[9].
- IDLE:
  - On start=1: latch g1/g2 into snapshot registers, load replicas to 3FF, count=0, busy=1, go to SEARCH.
  - If latched g1==0: go directly to DONE with err=01, phase=0.
- SEARCH, each cycle:
  - Compare replica G1 with the snapshot G1.
  - On G1 match: phase=count. If replica G2 also matches, err=00; otherwise err=10. Go to DONE.
  - No G1 match: step both replicas, count=count+1.
  - A nonzero G1 always matches by count 1022; no timeout state is needed.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE. phase and err hold until the next start is accepted.
- Latency: done is high in the cycle after edge p+1, counting from edge 0 where start is sampled. Phase 0 gives done one cycle after the start edge. Phase 1022 gives done 1023 cycles after it. All-zero error gives done one cycle after.
- start while busy or in DONE is ignored. A new start is accepted in the first IDLE cycle after DONE.
- g1/g2 may change after the start edge; only the latched copies are used.
- Reset mid-search aborts immediately to reset values. No done pulse is issued.
- count is 10 bits and never exceeds 1022; it never wraps.

Optional Feature:
TWO_STEP_EN
- Defined: each SEARCH cycle evaluates candidates count and count+1, using a second combinational step of the replicas.
  - The lower matching candidate wins.
  - count and replicas advance by two chips per cycle.
  - At count=1022 only candidate 1022 is compared; candidate 1023 is never formed.
  - Latency is floor(p/2)+1 cycles.
  - The err and phase rules are unchanged.
- Undefined: single-step search as described above.

Test Plan:
- Reset: hold rst=0 for 2 cycles with start=1 -> busy=0, done=0, phase=0, err=00. No search starts.
- Epoch: start with g1=g2=10'h3FF -> done one cycle after the start edge, phase=0, err=00.
- Step one: start with g1=g2=10'h3FE -> phase=1, err=00, done two cycles after start (TWO_STEP_EN: one cycle).
- Last chip: start with g1=g2=10'h1FF -> phase=1022, err=00, done 1023 cycles after start (TWO_STEP_EN: 512). Then, for the full sweep, drive every state produced by the forward mapper for phases 0..1022 -> recovered phase equals the source phase for all 1023.
- Errors:
  - g1=0 -> err=01, phase=0, done one cycle after start.
  - g1=3FF, g2=3FE -> err=10, phase=0.
- Robustness:
  - Pulse start again mid-search for phase 500 -> ignored; result phase=500.
  - Assert rst=0 mid-search -> no done pulse; outputs return to reset values.
